// File: rtl/fs_accel_pkg.sv
// Shared definitions for the feature-stream input scheduler: state encoding and
// default address/dimension widths.
package fs_accel_pkg;

    localparam int unsigned AddrWDefault = 16;
    localparam int unsigned DimWDefault  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StWin   = 2'd2,
        StFin   = 2'd3
    } isched_state_e;

endpackage

// File: rtl/fs_accel_isched_agen.sv
// Row/column counters and read-address generator for the input scheduler.
// Image dimensions and the row base address are latched on job init.
module fs_accel_isched_agen
    import fs_accel_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DIM_W  = DimWDefault
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init_i,
    input  logic              col_inc_i,
    input  logic              row_next_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [DIM_W-1:0]  img_w_i,
    input  logic [DIM_W-1:0]  img_h_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DIM_W-1:0]  row_o,
    output logic [DIM_W-1:0]  col_o,
    output logic              col_ge2_o,
    output logic              col_end_o,
    output logic              row_end_o
);

    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  w_q, w_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        w_d    = w_q;
        h_d    = h_q;
        base_d = base_q;
        if (init_i) begin
            row_d  = '0;
            col_d  = '0;
            w_d    = img_w_i;
            h_d    = img_h_i;
            base_d = base_addr_i;
        end else if (row_next_i) begin
            row_d  = row_q + DIM_W'(1);
            col_d  = '0;
            base_d = base_q + ADDR_W'(w_q);
        end else if (col_inc_i) begin
            col_d = col_q + DIM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_q  <= '0;
            col_q  <= '0;
            w_q    <= '0;
            h_q    <= '0;
            base_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            w_q    <= w_d;
            h_q    <= h_d;
            base_q <= base_d;
        end
    end

    // Address wraps naturally at ADDR_W bits.
    assign rd_addr_o = base_q + ADDR_W'(col_q);
    assign row_o     = row_q;
    assign col_o     = col_q;
    assign col_ge2_o = (col_q >= DIM_W'(2));
    assign col_end_o = (col_q == (w_q - DIM_W'(1)));
    assign row_end_o = (row_q >= (h_q - DIM_W'(3)));

endmodule

// File: rtl/fs_accel_isched.sv
// 3x3 window input scheduler: fetches image columns and presents windows downstream.
// Define FS_ACCEL_ISCHED_PERF_EN to add the 16-bit perf_stall window-stall counter.
module fs_accel_isched
    import fs_accel_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DIM_W  = DimWDefault
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              ireg_enb,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DIM_W-1:0]  row_idx,
`ifdef FS_ACCEL_ISCHED_PERF_EN
    output logic [15:0]       perf_stall,
`endif
    output logic [DIM_W-1:0]  col_idx
);

    isched_state_e     state_q, state_d;
    logic              err_q, err_d;
    logic              start_acc, agen_init, col_inc, row_next;
    logic              rd_req_c, ireg_c, win_c, done_c;
    logic              dims_bad;
    logic [ADDR_W-1:0] agen_addr;
    logic [DIM_W-1:0]  agen_row, agen_col;
    logic              col_ge2, col_end, row_end;

    assign dims_bad = (img_w < DIM_W'(3)) || (img_h < DIM_W'(3));

    fs_accel_isched_agen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_agen (
        .clk         (clk),
        .resetn      (resetn),
        .init_i      (agen_init),
        .col_inc_i   (col_inc),
        .row_next_i  (row_next),
        .base_addr_i (base_addr),
        .img_w_i     (img_w),
        .img_h_i     (img_h),
        .rd_addr_o   (agen_addr),
        .row_o       (agen_row),
        .col_o       (agen_col),
        .col_ge2_o   (col_ge2),
        .col_end_o   (col_end),
        .row_end_o   (row_end)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        start_acc = 1'b0;
        agen_init = 1'b0;
        col_inc   = 1'b0;
        row_next  = 1'b0;
        rd_req_c  = 1'b0;
        ireg_c    = 1'b0;
        win_c     = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (dims_bad) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        err_d     = 1'b0;
                        agen_init = 1'b1;
                        state_d   = StFetch;
                    end
                end
            end
            StFetch: begin
                rd_req_c = 1'b1;
                ireg_c   = rd_valid;
                if (rd_valid) begin
                    if (col_ge2) begin
                        state_d = StWin;
                    end else begin
                        col_inc = 1'b1;
                    end
                end
            end
            StWin: begin
                win_c = 1'b1;
                if (win_ready) begin
                    if (!col_end) begin
                        col_inc = 1'b1;
                        state_d = StFetch;
                    end else if (!row_end) begin
                        row_next = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                done_c  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Reset is synchronous, so outputs are gated directly to read zero during it.
    assign busy      = resetn && (state_q != StIdle);
    assign done      = resetn && done_c;
    assign err       = resetn && err_q;
    assign rd_req    = resetn && rd_req_c;
    assign rd_addr   = (resetn && rd_req_c) ? agen_addr : '0;
    assign ireg_enb  = resetn && ireg_c;
    assign win_valid = resetn && win_c;
    assign row_idx   = resetn ? agen_row : '0;
    assign col_idx   = resetn ? agen_col : '0;

`ifdef FS_ACCEL_ISCHED_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (win_c && !win_ready && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = resetn ? perf_q : '0;
`endif

endmodule

// File: tb/tb_fs_accel_isched.sv
// Directed self-checking bench for fs_accel_isched with a one-cycle-latency memory model.
module tb_fs_accel_isched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0;
    logic [7:0]  img_w = 8'd0;
    logic [7:0]  img_h = 8'd0;
    logic        busy, done, err, rd_req, ireg_enb, win_valid;
    logic [15:0] rd_addr;
    logic        rd_valid = 1'b0;
    logic        win_ready = 1'b1;
    logic [7:0]  row_idx, col_idx;
`ifdef FS_ACCEL_ISCHED_PERF_EN
    logic [15:0] perf_stall;
`endif

    int total = 0;
    int bad = 0;

    bit          mem_en = 1'b1;
    bit          late_valid = 1'b0;
    bit          pend = 1'b0;
    int          cyc = 0;
    int          n_reads = 0;
    int          n_wins = 0;
    int          n_done = 0;
    int          last_win_cyc = 0;
    int          done_cyc = 0;
    int          ireg_bad = 0;
    logic [15:0] addr_q[$];

    always #10 clk = ~clk;

    fs_accel_isched dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_addr  (base_addr),
        .img_w      (img_w),
        .img_h      (img_h),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .ireg_enb   (ireg_enb),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .row_idx    (row_idx),
`ifdef FS_ACCEL_ISCHED_PERF_EN
        .perf_stall (perf_stall),
`endif
        .col_idx    (col_idx)
    );

    // Memory model (data one cycle after the request) and transaction logger.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mem_en) begin
                if (rd_valid) begin
                    rd_valid = 1'b0;
                    pend = rd_req;
                end else if (pend) begin
                    rd_valid = 1'b1;
                    pend = 1'b0;
                end else begin
                    pend = rd_req;
                end
            end else begin
                pend = 1'b0;
                rd_valid = late_valid;
            end
            #2;
            if (rd_req && rd_valid) begin
                n_reads++;
                addr_q.push_back(rd_addr);
            end
            if (ireg_enb !== (rd_req && rd_valid)) ireg_bad++;
            if (win_valid && win_ready) begin
                n_wins++;
                last_win_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic launch(input logic [15:0] b, input logic [7:0] w, input logic [7:0] h);
        base_addr = b;
        img_w = w;
        img_h = h;
        n_reads = 0;
        n_wins = 0;
        n_done = 0;
        addr_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        total++;
        if (n_done == 0) begin
            bad++;
            $display("FAIL %s_done_timeout: n_done=%0d want 1", name, n_done);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({busy, done, err, rd_req, ireg_enb, win_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, err, rd_req, ireg_enb, win_valid});
        end
        total++;
        if (rd_addr !== 16'h0 || row_idx !== 8'h0 || col_idx !== 8'h0) begin
            bad++;
            $display("FAIL reset_idx: addr=%h row=%0d col=%0d want 0", rd_addr, row_idx, col_idx);
        end
        resetn = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        launch(16'h0100, 8'd5, 8'd4);
        wait_done(400, "basic");
        total++;
        if (n_reads !== 10) begin
            bad++;
            $display("FAIL basic_reads: got %0d want 10", n_reads);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (i >= addr_q.size() || addr_q[i] !== (16'h0100 + 16'(i))) begin
                bad++;
                $display("FAIL basic_addr%0d: got %h want %h", i,
                         (i < addr_q.size()) ? addr_q[i] : 16'hxxxx, 16'h0100 + 16'(i));
            end
        end
        total++;
        if (n_wins !== 6) begin
            bad++;
            $display("FAIL basic_wins: got %0d want 6", n_wins);
        end
        total++;
        if (done_cyc !== last_win_cyc + 1) begin
            bad++;
            $display("FAIL basic_done_lat: done at %0d want %0d", done_cyc, last_win_cyc + 1);
        end
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_illegal();
        launch(16'h0200, 8'd2, 8'd8);
        total++;
        if (done !== 1'b1 || err !== 1'b1 || rd_req !== 1'b0) begin
            bad++;
            $display("FAIL illegal_fin: done=%b err=%b rd_req=%b want 1 1 0", done, err, rd_req);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_after: done=%b busy=%b err=%b want 0 0 1", done, busy, err);
        end
        launch(16'h0200, 8'd8, 8'd2);
        total++;
        if (done !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_h: done=%b err=%b want 1 1", done, err);
        end
        step();
        total++;
        if (n_reads !== 0) begin
            bad++;
            $display("FAIL illegal_reads: got %0d want 0", n_reads);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        win_ready = 1'b0;
        launch(16'h0020, 8'd3, 8'd3);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL stall_err_clear: err=%b want 0", err);
        end
        while (win_valid !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        total++;
        if (win_valid !== 1'b1 || row_idx !== 8'd0 || col_idx !== 8'd2) begin
            bad++;
            $display("FAIL stall_first_win: win_valid=%b row=%0d col=%0d want 1 0 2",
                     win_valid, row_idx, col_idx);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (win_valid !== 1'b1 || rd_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: win_valid=%b rd_req=%b want 1 0", i, win_valid, rd_req);
            end
            step();
        end
        win_ready = 1'b1;
        wait_done(100, "stall");
        total++;
        if (n_wins !== 1 || n_reads !== 3) begin
            bad++;
            $display("FAIL stall_counts: wins=%0d reads=%0d want 1 3", n_wins, n_reads);
        end
`ifdef FS_ACCEL_ISCHED_PERF_EN
        total++;
        if (perf_stall !== 16'd7) begin
            bad++;
            $display("FAIL stall_perf: got %0d want 7", perf_stall);
        end
`endif
    endtask

    task automatic test_ignore_start();
        int k = 0;
        launch(16'h0040, 8'd4, 8'd3);
`ifdef FS_ACCEL_ISCHED_PERF_EN
        total++;
        if (perf_stall !== 16'd0) begin
            bad++;
            $display("FAIL ignore_perf_clear: got %0d want 0", perf_stall);
        end
`endif
        img_w = 8'd2;
        img_h = 8'd2;
        base_addr = 16'hBEEF;
        while (busy === 1'b1 && k < 400) begin
            start = 1'b1;
            step();
            k++;
        end
        start = 1'b0;
        step();
        step();
        total++;
        if (n_reads !== 4 || n_wins !== 2 || n_done !== 1) begin
            bad++;
            $display("FAIL ignore_counts: reads=%0d wins=%0d done=%0d want 4 2 1",
                     n_reads, n_wins, n_done);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= addr_q.size() || addr_q[i] !== (16'h0040 + 16'(i))) begin
                bad++;
                $display("FAIL ignore_addr%0d: want %h", i, 16'h0040 + 16'(i));
            end
        end
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL ignore_end: busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a[3];
        exp_a[0] = 16'hFFFE;
        exp_a[1] = 16'hFFFF;
        exp_a[2] = 16'h0000;
        launch(16'hFFFE, 8'd3, 8'd3);
        wait_done(100, "wrap");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= addr_q.size() || addr_q[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL wrap_addr%0d: want %h", i, exp_a[i]);
            end
        end
        total++;
        if (n_wins !== 1 || n_reads !== 3) begin
            bad++;
            $display("FAIL wrap_counts: wins=%0d reads=%0d want 1 3", n_wins, n_reads);
        end
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b0;
        late_valid = 1'b0;
        step();
        launch(16'h0300, 8'd5, 8'd4);
        step();
        total++;
        if (rd_req !== 1'b1 || rd_addr !== 16'h0300 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_fetch: rd_req=%b addr=%h busy=%b want 1 0300 1",
                     rd_req, rd_addr, busy);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({busy, done, err, rd_req, ireg_enb, win_valid} !== 6'b0 || rd_addr !== 16'h0 ||
            row_idx !== 8'h0 || col_idx !== 8'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: flags=%b addr=%h want all 0",
                     {busy, done, err, rd_req, ireg_enb, win_valid}, rd_addr);
        end
        step();
        resetn = 1'b1;
        late_valid = 1'b1;
        #5;
        total++;
        if (ireg_enb !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_late_valid: ireg=%b busy=%b rd_req=%b want 0 0 0",
                     ireg_enb, busy, rd_req);
        end
        step();
        late_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || rd_addr !== 16'h0) begin
            bad++;
            $display("FAIL rstmid_idle: busy=%b addr=%h want 0 0000", busy, rd_addr);
        end
        step();
        mem_en = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_stall();
        test_ignore_start();
        test_wrap();
        test_reset_mid();
        total++;
        if (ireg_bad !== 0) begin
            bad++;
            $display("FAIL ireg_enb_tracking: %0d cycles differed from rd_req&&rd_valid", ireg_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
